// File: rtl/typeracer_pkg.sv
// Shared constants and state encoding for the TypeRacer text path.
package typeracer_pkg;

    localparam int CW      = 5;
    localparam int N_CHARS = 25;

    localparam logic [4:0] CH_BLANK = 5'd0;
    localparam logic [4:0] CH_SPACE = 5'd27;
    localparam logic [4:0] CH_MAX   = 5'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sec_timer.sv
// Elapsed-seconds timer: free tick counter that wraps once per second and a
// saturating 15-bit seconds count. Counts only while en is high.
module sec_timer #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [14:0] times
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

    logic [TW-1:0] r_tick;
    logic [14:0]   r_sec;

    // Tick counter and saturating seconds; clr restarts both from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_tick <= '0;
            r_sec  <= '0;
        end else if (en) begin
            if (r_tick == TICK_LAST) begin
                r_tick <= '0;
                if (r_sec != '1) begin
                    r_sec <= r_sec + 15'd1;
                end
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    assign times = r_sec;

endmodule

// File: rtl/type_ctrl.sv
// Keystroke sequencer: game FSM, typed-text array, per-slot correctness
// against the target sentence and the elapsed-seconds timer.
module type_ctrl #(
    parameter int N_CHARS       = 25,
    parameter int CW            = 5,
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  key_valid,
    input  logic [CW-1:0]         key_code,
    input  logic                  key_bksp,
    input  logic [N_CHARS*CW-1:0] target,
    input  logic [4:0]            tot,
    output logic [N_CHARS*CW-1:0] type_out,
    output logic [N_CHARS-1:0]    correct,
    output logic [4:0]            correct_cnt,
    output logic [14:0]           times,
    output logic                  busy,
    output logic                  done
);

    import typeracer_pkg::*;

    localparam int IW = $clog2(N_CHARS + 1);

    state_t                r_state;
    logic [N_CHARS*CW-1:0] r_type;
    logic [N_CHARS-1:0]    r_correct;
    logic [4:0]            r_cnt;
    logic [IW-1:0]         r_cur;
    logic [IW-1:0]         r_len;

    logic [IW-1:0]         w_len;
    logic [IW-1:0]         w_next;
    logic [IW-1:0]         w_prev;
    logic                  w_char;
    logic                  w_run;
    logic [4:0]            w_pop;

    assign w_len  = (int'(tot) > N_CHARS) ? IW'(N_CHARS) : IW'(tot);
    assign w_next = r_cur + 1'b1;
    assign w_prev = r_cur - 1'b1;
    assign w_char = (key_code != CW'(CH_BLANK)) && (key_code <= CW'(CH_MAX));
    assign w_run  = (r_state == RUN);

    // FSM, text array and correctness; start takes priority over any key.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_type    <= '0;
            r_correct <= '0;
            r_cur     <= '0;
            r_len     <= '0;
        end else if (start) begin
            r_len     <= w_len;
            r_type    <= '0;
            r_correct <= '0;
            r_cur     <= '0;
            r_state   <= (w_len == '0) ? DONE : RUN;
        end else if (w_run && key_valid) begin
            if (key_bksp) begin
                if (r_cur != '0) begin
                    r_type[w_prev*CW +: CW] <= '0;
                    r_correct[w_prev]       <= 1'b0;
                    r_cur                   <= w_prev;
                end
            end else if (w_char && (r_cur < r_len)) begin
                r_type[r_cur*CW +: CW] <= key_code;
                r_correct[r_cur]       <= (key_code == target[r_cur*CW +: CW]);
                r_cur                  <= w_next;
                if (w_next == r_len) begin
                    r_state <= DONE;
                end
            end
        end
    end

    // Popcount of the registered correctness vector.
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < N_CHARS; i++) begin
            w_pop = w_pop + 5'(r_correct[i]);
        end
    end

    // Correct count lags the correctness vector by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_pop;
        end
    end

    sec_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (w_run),
        .times(times)
    );

    assign type_out    = r_type;
    assign correct     = r_correct;
    assign correct_cnt = r_cnt;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);

endmodule

// File: tb/tb_type_ctrl.sv
// Directed bench for type_ctrl: one instance with a 10-cycle second and a
// second instance with a 1-cycle second to reach seconds saturation quickly.
module tb_type_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_bksp;
    logic [124:0] target;
    logic [4:0]   tot;

    logic [124:0] type_out,  type_out2;
    logic [24:0]  correct,   correct2;
    logic [4:0]   cnt,       cnt2;
    logic [14:0]  times,     times2;
    logic         busy, done, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [124:0] exp_type;

    always #5 clk = ~clk;

    type_ctrl #(
        .N_CHARS(25),
        .CW(5),
        .TICKS_PER_SEC(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
        .key_code(key_code), .key_bksp(key_bksp), .target(target), .tot(tot),
        .type_out(type_out), .correct(correct), .correct_cnt(cnt),
        .times(times), .busy(busy), .done(done)
    );

    type_ctrl #(
        .N_CHARS(25),
        .CW(5),
        .TICKS_PER_SEC(1)
    ) dut_fast (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
        .key_code(key_code), .key_bksp(key_bksp), .target(target), .tot(tot),
        .type_out(type_out2), .correct(correct2), .correct_cnt(cnt2),
        .times(times2), .busy(busy2), .done(done2)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic key(input logic [4:0] code);
        key_valid = 1'b1;
        key_bksp  = 1'b0;
        key_code  = code;
        cyc();
        key_valid = 1'b0;
    endtask

    task automatic bksp();
        key_valid = 1'b1;
        key_bksp  = 1'b1;
        key_code  = 5'd9;
        cyc();
        key_valid = 1'b0;
        key_bksp  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = '0;
        key_bksp = 1'b0; target = '0; tot = '0;
        repeat (3) cyc();
        rst = 1'b0;

        // Idle with random keys: nothing may change.
        for (int i = 0; i < 100; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_bksp  = 1'($urandom_range(0, 1));
            key_code  = 5'($urandom_range(0, 31));
            cyc();
        end
        key_valid = 1'b0; key_bksp = 1'b0;
        check_val("idle_type", type_out, 0);
        check_val("idle_correct", correct, 0);
        check_val("idle_cnt", cnt, 0);
        check_val("idle_times", times, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_done", done, 0);

        // "cat", all correct.
        target = '0;
        target[4:0] = 5'd3; target[9:5] = 5'd1; target[14:10] = 5'd20;
        tot = 5'd3;
        pulse_start();
        check_val("cat_busy", busy, 1);
        key(5'd3); key(5'd1); key(5'd20);
        exp_type = '0;
        exp_type[4:0] = 5'd3; exp_type[9:5] = 5'd1; exp_type[14:10] = 5'd20;
        check_val("cat_type", type_out, exp_type);
        check_val("cat_correct", correct, 25'b111);
        check_val("cat_done", done, 1);
        check_val("cat_busy_low", busy, 0);
        cyc();
        check_val("cat_cnt", cnt, 3);
        key(5'd5);
        check_val("done_freeze", type_out, exp_type);

        // Partial mismatch.
        pulse_start();
        key(5'd3); key(5'd2);
        cyc();
        check_val("mix_correct", correct, 25'b01);
        check_val("mix_cnt", cnt, 1);
        check_val("mix_busy", busy, 1);

        // Backspace underflow and invalid codes.
        tot = 5'd4;
        pulse_start();
        key(5'd1); key(5'd2);
        bksp(); bksp(); bksp();
        key(5'd0); key(5'd30);
        check_val("bk_type", type_out, 0);
        check_val("bk_correct", correct, 0);
        check_val("bk_busy", busy, 1);
        check_val("bk_done", done, 0);
        key(5'd3);
        exp_type = '0; exp_type[4:0] = 5'd3;
        check_val("bk_slot0", type_out, exp_type);
        check_val("bk_slot0_ok", correct, 25'b1);

        // Timer and seconds saturation.
        pulse_start();
        repeat (35) cyc();
        check_val("times_35", times, 3);
        check_val("fast_times_35", times2, 35);
        repeat (32800) cyc();
        check_val("times_long", times, 3283);
        check_val("fast_sat", times2, 15'd32767);

        // start+key collision, then restart mid-round.
        tot = 5'd2;
        start = 1'b1; key_valid = 1'b1; key_code = 5'd3;
        cyc();
        start = 1'b0; key_valid = 1'b0;
        check_val("collide_type", type_out, 0);
        check_val("collide_busy", busy, 1);
        key(5'd3);
        exp_type = '0; exp_type[4:0] = 5'd3;
        check_val("one_key", type_out, exp_type);
        repeat (11) cyc();
        check_val("times_one", times, 1);
        pulse_start();
        check_val("restart_type", type_out, 0);
        check_val("restart_correct", correct, 0);
        check_val("restart_times", times, 0);
        check_val("restart_busy", busy, 1);

        // Zero length goes straight to DONE.
        tot = 5'd0;
        pulse_start();
        check_val("len0_done", done, 1);
        check_val("len0_busy", busy, 0);

        // Length clamped to 25.
        for (int i = 0; i < 25; i++) target[i*5 +: 5] = 5'((i % 27) + 1);
        tot = 5'd31;
        pulse_start();
        for (int i = 0; i < 24; i++) key(5'((i % 27) + 1));
        check_val("clamp_busy24", busy, 1);
        check_val("clamp_done24", done, 0);
        key(5'd25);
        check_val("clamp_done", done, 1);
        check_val("clamp_type", type_out, target);
        check_val("clamp_correct", correct, 25'h1FFFFFF);
        cyc();
        check_val("clamp_cnt", cnt, 25);

        // Reset mid-round.
        tot = 5'd10;
        pulse_start();
        for (int i = 0; i < 5; i++) key(5'(i + 1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("rst_type", type_out, 0);
        check_val("rst_correct", correct, 0);
        check_val("rst_cnt", cnt, 0);
        check_val("rst_times", times2, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/type_ctrl.md
# type_ctrl

Keystroke-sequencing controller for the TypeRacer display path. It accepts decoded key events, maintains the packed 25-character typed-text array that the VGA text renderer draws, and tracks per-character correctness against the target sentence and elapsed seconds. It runs a three-state game FSM (IDLE/RUN/DONE) and sits between the keyboard decoder and the `vga` top.

## Interface
- `N_CHARS`, default 25: maximum sentence length in characters.
- `CW`, default 5: character code width.
- `TICKS_PER_SEC`, default 100_000_000: `clk` cycles per second.
- `clk`  in  1  system clock (100 MHz); single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse: begin or restart a round.
- `key_valid`  in  1  one-cycle strobe: key event present.
- `key_code`  in  CW  character code 1..26 = a..z, 27 = space; other codes are invalid.
- `key_bksp`  in  1  qualifies `key_valid` as backspace; `key_code` is ignored.
- `target`  in  N_CHARS*CW  target sentence; char i at [CW*i+CW-1 : CW*i].
- `tot`  in  5  target length.
- `type`  out  N_CHARS*CW  typed text, same packing; 0 = blank.
- `correct`  out  N_CHARS  bit i = typed char i equals target char i.
- `correct_cnt`  out  5  popcount of `correct`.
- `times`  out  15  elapsed seconds since start, saturating.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- Reset: state IDLE. `type`, `correct`, `correct_cnt`, `times`, cursor, tick counter = 0. `busy` = 0, `done` = 0.
- Effective length L = min(`tot`, N_CHARS), sampled into a register on `start`.
- IDLE: outputs hold; keys are ignored. On `start`, clear `type`, `correct`, cursor, `times` and the tick counter, then enter RUN. If L = 0, enter DONE directly.
- RUN:
  - Valid char key with cursor < L: write the code to slot[cursor], update `correct`[cursor], cursor++.
  - Backspace with cursor > 0: cursor--, clear slot[cursor-1] to 0 and clear `correct`[cursor-1].
  - Backspace at cursor = 0 is a no-op.
  - Invalid codes (0, 28..31) are ignored and leave cursor and text unchanged.
  - When a write makes cursor = L, the next state is DONE. DONE is entered regardless of correctness.
- DONE: `type`, `correct` and `times` freeze; keys are ignored. `start` restarts exactly as from IDLE.
- `start` in RUN restarts the round immediately.
- `start` and `key_valid` in the same cycle: `start` wins and the key is dropped.
- Timer (RUN only):
  - Tick counter wraps at TICKS_PER_SEC-1.
  - `times` increments on each wrap and saturates at 32767.
  - The counter does not advance in IDLE or DONE.
- Slots at index ≥ L are always 0 in `type` and `correct`.

## Timing
- Key strobe at cycle n: `type` and `correct` are updated at the n+1 edge. `correct_cnt` is registered from `correct` and updates at n+2.
- Final key at n: `done` = 1 and `busy` = 0 from n+1.
- `start` at n: cleared outputs and `busy` = 1 from n+1. The first `times` increment comes TICKS_PER_SEC cycles later.
- Reset asserted mid-round overrides everything on that edge. Outputs equal reset values from the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Key events are accepted one per cycle, back-to-back, with no backpressure.

## Structure
- Shared package `typeracer_pkg`:
  - constants `CW`, `N_CHARS`, `CH_BLANK` = 0, `CH_SPACE` = 27, `CH_MAX` = 27;
  - state typedef {IDLE, RUN, DONE}.
- Sub-module `sec_timer`: tick counter plus saturating 15-bit seconds counter, with `clr` and `en` inputs. The FSM, text array and correctness logic stay in `type_ctrl`.

## Test plan
- Reset, then idle for 100 cycles with random keys -> all outputs 0, `busy` = 0, `done` = 0.
- tot = 3, target "cat" (3,1,20); start; keys 3,1,20 -> `type` slots 3,1,20; `correct` = 3'b111, `correct_cnt` = 3 at n+2 after the last key; `done` = 1 one cycle after the last key.
- tot = 4; keys 1,2, bksp, bksp, bksp, then 0 and 30 -> cursor = 0, `type` = 0, state RUN, no underflow.
- TICKS_PER_SEC = 10; start; wait 35 cycles -> `times` = 3. Force 32767 wraps -> `times` holds at 32767.
- tot = 2; start and key in the same cycle -> key dropped, `type` = 0. `start` mid-round after 1 key -> `type` cleared and `times` = 0 at the next cycle.
- tot = 31 -> L = 25; 25 keys -> DONE. `rst` asserted in RUN with 5 chars typed -> all reset values next cycle.
